iod_rx_delay_trainer: RTL and testbench

//  Initiator-side controller for the generic IOD RX lane controller. It drives DELAY_LINE_* and HS_IO_CLK_PAUSE.
//  It sweeps the RX DQS delay line tap by tap and checks the deserialised word against a known training pattern.
//  It then locates the first valid eye window and parks the delay line at the window centre.

---
 rtl/iod_rx_delay_trainer_if.sv | 36 +++
 rtl/iod_rx_delay_trainer.sv | 256 +++++++++++++++++++++++++
 tb/tb_iod_rx_delay_trainer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/iod_rx_delay_trainer_if.sv
// Bundle of lane-side signals between the RX delay trainer and the IOD
// wrapper / fabric. The trainer connects through the slave modport; the
// environment that feeds RX data and consumes status uses the master modport.
interface iod_rx_delay_trainer_if #(
    parameter int DATA_W = 8,
    parameter int TAP_W  = 7
);
    logic              start;
    logic [DATA_W-1:0] rx_data;
    logic              rx_delay_line_out_of_range;
    logic              delay_line_sel;
    logic              delay_line_load;
    logic              delay_line_direction;
    logic              delay_line_move;
    logic              hs_io_clk_pause;
    logic              busy;
    logic              done;
    logic              error;
    logic [TAP_W-1:0]  win_start;
    logic [TAP_W-1:0]  win_end;
    logic [TAP_W-1:0]  center_tap;

    modport master (
        output start, rx_data, rx_delay_line_out_of_range,
        input  delay_line_sel, delay_line_load, delay_line_direction,
               delay_line_move, hs_io_clk_pause, busy, done, error,
               win_start, win_end, center_tap
    );

    modport slave (
        input  start, rx_data, rx_delay_line_out_of_range,
        output delay_line_sel, delay_line_load, delay_line_direction,
               delay_line_move, hs_io_clk_pause, busy, done, error,
               win_start, win_end, center_tap
    );
endinterface

// File: rtl/iod_rx_delay_trainer.sv
// RX DQS delay-line trainer. Sweeps the delay line one tap at a time,
// qualifies each tap by comparing the deserialised word against a fixed
// training pattern, keeps the first passing window that is wide enough and
// finally parks the delay line at the centre of that window.
// Every delay-line load/move is wrapped in a three-cycle clock pause with the
// load/move pulse in the middle cycle. All outputs are registered.
module iod_rx_delay_trainer #(
    parameter int               DATA_W     = 8,
    parameter logic [DATA_W-1:0] PATTERN   = 8'h5A,
    parameter int               TAP_W      = 7,
    parameter int               MAX_TAPS   = 128,
    parameter int               SETTLE_CYC = 8,
    parameter int               CHECK_CYC  = 16,
    parameter int               MIN_WIN    = 4
) (
    input  logic                   fab_clk_i,
    input  logic                   reset_i,
    iod_rx_delay_trainer_if.slave  bus_if
);

    localparam int CNT_MAX = (SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYC - 1);
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(MAX_TAPS - 1);
    localparam logic [TAP_W:0]   MIN_WIN_W   = (TAP_W + 1)'(MIN_WIN);

    // S_LOAD / S_RELOAD / S_MOVE are the three pulse sequences; ph_q walks
    // through their cycles (0: pause only, 1: pause + pulse, 2: pause only).
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_SETTLE = 4'd2,
        S_CHECK  = 4'd3,
        S_STEP   = 4'd4,
        S_MOVE   = 4'd5,
        S_CALC   = 4'd6,
        S_RELOAD = 4'd7,
        S_SEEK   = 4'd8,
        S_DONE   = 4'd9,
        S_FAIL   = 4'd10
    } state_t;

    state_t             state_q;
    logic [1:0]         ph_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TAP_W-1:0]   tap_q;
    logic               in_win_q;
    logic               pass_q;
    logic               seek_ret_q;
    logic [TAP_W-1:0]   win_start_q;
    logic [TAP_W-1:0]   win_end_q;
    logic [TAP_W-1:0]   center_q;
    logic               sel_q;
    logic               load_q;
    logic               dir_q;
    logic               move_q;
    logic               pause_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;

    logic               pass_d;
    logic [TAP_W:0]     width_d;
    logic [TAP_W:0]     sum_d;
    logic               win_ok_d;

    // Per-tap pass accumulation, current window width and centre sum.
    always_comb begin
        pass_d   = pass_q & (bus_if.rx_data == PATTERN);
        width_d  = {1'b0, win_end_q} - {1'b0, win_start_q} + (TAP_W + 1)'(1);
        sum_d    = {1'b0, win_start_q} + {1'b0, win_end_q};
        win_ok_d = in_win_q & (width_d >= MIN_WIN_W);
    end

    // Training FSM with all status and delay-line controls registered.
    always_ff @(posedge fab_clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            ph_q        <= 2'd0;
            cnt_q       <= '0;
            tap_q       <= '0;
            in_win_q    <= 1'b0;
            pass_q      <= 1'b0;
            seek_ret_q  <= 1'b0;
            win_start_q <= '0;
            win_end_q   <= '0;
            center_q    <= '0;
            sel_q       <= 1'b0;
            load_q      <= 1'b0;
            dir_q       <= 1'b0;
            move_q      <= 1'b0;
            pause_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (bus_if.start) begin
                        state_q  <= S_LOAD;
                        ph_q     <= 2'd0;
                        pause_q  <= 1'b1;
                        sel_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        error_q  <= 1'b0;
                        in_win_q <= 1'b0;
                    end
                end

                S_LOAD, S_RELOAD, S_MOVE: begin
                    case (ph_q)
                        2'd0: begin
                            if (state_q == S_MOVE) begin
                                move_q <= 1'b1;
                                dir_q  <= 1'b1;
                            end else begin
                                load_q <= 1'b1;
                            end
                            ph_q <= 2'd1;
                        end
                        2'd1: begin
                            load_q <= 1'b0;
                            move_q <= 1'b0;
                            dir_q  <= 1'b0;
                            ph_q   <= 2'd2;
                        end
                        default: begin
                            pause_q <= 1'b0;
                            ph_q    <= 2'd0;
                            if (state_q == S_LOAD) begin
                                tap_q   <= '0;
                                cnt_q   <= '0;
                                state_q <= S_SETTLE;
                            end else if (state_q == S_RELOAD) begin
                                tap_q   <= '0;
                                state_q <= S_SEEK;
                            end else begin
                                tap_q <= tap_q + TAP_W'(1);
                                if (seek_ret_q) begin
                                    state_q <= S_SEEK;
                                end else begin
                                    cnt_q   <= '0;
                                    state_q <= S_SETTLE;
                                end
                            end
                        end
                    endcase
                end

                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        pass_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_CHECK: begin
                    pass_q <= pass_d;
                    if (cnt_q == CHECK_LAST) begin
                        cnt_q <= '0;
                        if (pass_d) begin
                            if (!in_win_q) begin
                                win_start_q <= tap_q;
                                in_win_q    <= 1'b1;
                            end
                            win_end_q <= tap_q;
                            state_q   <= S_STEP;
                        end else if (win_ok_d) begin
                            // First qualifying window closed: stop sweeping.
                            state_q <= S_CALC;
                        end else begin
                            // Too-narrow window (if any) is forgotten.
                            in_win_q <= 1'b0;
                            state_q  <= S_STEP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_STEP: begin
                    if ((tap_q == LAST_TAP) || bus_if.rx_delay_line_out_of_range) begin
                        state_q <= S_CALC;
                    end else begin
                        seek_ret_q <= 1'b0;
                        pause_q    <= 1'b1;
                        ph_q       <= 2'd0;
                        state_q    <= S_MOVE;
                    end
                end

                S_CALC: begin
                    // A window still open at the end of the sweep is accepted
                    // here as long as it is wide enough.
                    if (win_ok_d) begin
                        center_q <= sum_d[TAP_W:1];
                        pause_q  <= 1'b1;
                        ph_q     <= 2'd0;
                        state_q  <= S_RELOAD;
                    end else begin
                        busy_q  <= 1'b0;
                        sel_q   <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= S_FAIL;
                    end
                end

                S_SEEK: begin
                    if (tap_q != center_q) begin
                        seek_ret_q <= 1'b1;
                        pause_q    <= 1'b1;
                        ph_q       <= 2'd0;
                        state_q    <= S_MOVE;
                    end else begin
                        busy_q  <= 1'b0;
                        sel_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    ph_q    <= 2'd0;
                    sel_q   <= 1'b0;
                    load_q  <= 1'b0;
                    dir_q   <= 1'b0;
                    move_q  <= 1'b0;
                    pause_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.delay_line_sel       = sel_q;
    assign bus_if.delay_line_load      = load_q;
    assign bus_if.delay_line_direction = dir_q;
    assign bus_if.delay_line_move      = move_q;
    assign bus_if.hs_io_clk_pause      = pause_q;
    assign bus_if.busy                 = busy_q;
    assign bus_if.done                 = done_q;
    assign bus_if.error                = error_q;
    assign bus_if.win_start            = win_start_q;
    assign bus_if.win_end              = win_end_q;
    assign bus_if.center_tap           = center_q;

endmodule

// File: tb/tb_iod_rx_delay_trainer.sv
// Self-checking bench for iod_rx_delay_trainer. A behavioural delay line
// follows the load/move pulses and presents either the training pattern or
// random noise depending on a per-tap pass map. Expected window, centre and
// pulse counts come from a run-scanning reference model over that map.
module tb_iod_rx_delay_trainer;

    localparam logic [7:0] PATTERN = 8'h5A;
    localparam int         MIN_WIN = 4;

    logic clk;
    logic rst;

    iod_rx_delay_trainer_if #(.DATA_W(8), .TAP_W(7)) bus_if ();

    iod_rx_delay_trainer dut (
        .fab_clk_i (clk),
        .reset_i   (rst),
        .bus_if    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit pass_map  [0:127];
    bit model_map [0:127];
    int oor_tap     = 1000;
    int corrupt_tap = -1;
    int corrupt_k   = 0;

    int tap_m       = 0;
    int since       = 0;
    int loads       = 0;
    int sweep_moves = 0;
    int seek_moves  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: first run of passing taps at least MIN_WIN wide, sweep
    // limited to tap 127 or the out-of-range tap.
    function automatic void ref_model(input int oor, output bit found, output int ws,
                                      output int we, output int ctr, output int mv);
        int last;
        int rs;
        last  = (oor < 127) ? oor : 127;
        rs    = -1;
        found = 1'b0;
        ws    = 0;
        we    = 0;
        mv    = last;
        for (int t = 0; t <= last && !found; t++) begin
            if (model_map[t]) begin
                if (rs < 0) rs = t;
            end else if (rs >= 0) begin
                if (t - rs >= MIN_WIN) begin
                    found = 1'b1;
                    ws    = rs;
                    we    = t - 1;
                    mv    = t;
                end
                rs = -1;
            end
        end
        if (!found && rs >= 0 && (last - rs + 1) >= MIN_WIN) begin
            found = 1'b1;
            ws    = rs;
            we    = last;
        end
        ctr = (ws + we) / 2;
    endfunction

    // Delay-line model, pulse-protocol invariants and RX data driver.
    initial begin
        logic [7:0] w;
        bus_if.rx_data = 8'h00;
        bus_if.rx_delay_line_out_of_range = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.delay_line_load) begin
                tap_m = 0;
                since = 0;
                loads++;
            end else if (bus_if.delay_line_move) begin
                tap_m++;
                since = 0;
                if (loads == 1) sweep_moves++;
                else seek_moves++;
            end else begin
                since++;
            end
            check("load_move_excl", {31'd0, bus_if.delay_line_load & bus_if.delay_line_move}, 32'd0);
            check("dir_eq_move", {31'd0, bus_if.delay_line_direction}, {31'd0, bus_if.delay_line_move});
            if (bus_if.delay_line_load || bus_if.delay_line_move)
                check("pulse_in_pause", {31'd0, bus_if.hs_io_clk_pause}, 32'd1);
            check("sel_eq_busy", {31'd0, bus_if.delay_line_sel}, {31'd0, bus_if.busy});

            bus_if.rx_delay_line_out_of_range = (tap_m >= oor_tap);
            w = 8'($urandom);
            if (w == PATTERN) w = w ^ 8'h01;
            if (tap_m < 128 && pass_map[tap_m] && !(tap_m == corrupt_tap && since == corrupt_k))
                bus_if.rx_data = PATTERN;
            else
                bus_if.rx_data = w;
        end
    end

    task automatic clear_map();
        for (int i = 0; i < 128; i++) pass_map[i] = 1'b0;
        oor_tap     = 1000;
        corrupt_tap = -1;
    endtask

    task automatic set_win(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) pass_map[i] = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},   {31'd0, bus_if.delay_line_sel},       32'd0);
        check({tag, "_load"},  {31'd0, bus_if.delay_line_load},      32'd0);
        check({tag, "_dir"},   {31'd0, bus_if.delay_line_direction}, 32'd0);
        check({tag, "_move"},  {31'd0, bus_if.delay_line_move},      32'd0);
        check({tag, "_pause"}, {31'd0, bus_if.hs_io_clk_pause},      32'd0);
        check({tag, "_busy"},  {31'd0, bus_if.busy},                 32'd0);
        check({tag, "_done"},  {31'd0, bus_if.done},                 32'd0);
        check({tag, "_error"}, {31'd0, bus_if.error},                32'd0);
        check({tag, "_wstart"}, {25'd0, bus_if.win_start},           32'd0);
        check({tag, "_wend"},  {25'd0, bus_if.win_end},              32'd0);
        check({tag, "_center"}, {25'd0, bus_if.center_tap},          32'd0);
    endtask

    // Starts a training run, checks the initial load sequence, waits for
    // completion and compares the outcome with the reference model.
    task automatic run_training(input string tag, input bit busy_poke);
        bit found;
        int ws, we, ctr, mv;
        bit finished;
        for (int i = 0; i < 128; i++) model_map[i] = pass_map[i];
        if (corrupt_tap >= 0) model_map[corrupt_tap] = 1'b0;
        ref_model(oor_tap, found, ws, we, ctr, mv);
        loads = 0;
        sweep_moves = 0;
        seek_moves = 0;

        @(negedge clk);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        check({tag, "_seq1_pause"}, {31'd0, bus_if.hs_io_clk_pause}, 32'd1);
        check({tag, "_seq1_load"},  {31'd0, bus_if.delay_line_load}, 32'd0);
        check({tag, "_seq1_busy"},  {31'd0, bus_if.busy},            32'd1);
        check({tag, "_seq1_sel"},   {31'd0, bus_if.delay_line_sel},  32'd1);
        @(negedge clk);
        check({tag, "_seq2_pause"}, {31'd0, bus_if.hs_io_clk_pause}, 32'd1);
        check({tag, "_seq2_load"},  {31'd0, bus_if.delay_line_load}, 32'd1);
        @(negedge clk);
        check({tag, "_seq3_pause"}, {31'd0, bus_if.hs_io_clk_pause}, 32'd1);
        check({tag, "_seq3_load"},  {31'd0, bus_if.delay_line_load}, 32'd0);
        @(negedge clk);
        check({tag, "_seq4_pause"}, {31'd0, bus_if.hs_io_clk_pause}, 32'd0);

        finished = 1'b0;
        for (int c = 0; c < 20000 && !finished; c++) begin
            @(negedge clk);
            if (busy_poke) bus_if.start = (c >= 200 && c < 205);
            finished = bus_if.done | bus_if.error;
        end
        bus_if.start = 1'b0;
        check({tag, "_finished"}, {31'd0, finished}, 32'd1);
        check({tag, "_busy"},  {31'd0, bus_if.busy},           32'd0);
        check({tag, "_sel"},   {31'd0, bus_if.delay_line_sel}, 32'd0);
        check({tag, "_done"},  {31'd0, bus_if.done},           {31'd0, found});
        check({tag, "_error"}, {31'd0, bus_if.error},          {31'd0, !found});
        if (found) begin
            check({tag, "_wstart"}, {25'd0, bus_if.win_start},  32'(ws));
            check({tag, "_wend"},   {25'd0, bus_if.win_end},    32'(we));
            check({tag, "_center"}, {25'd0, bus_if.center_tap}, 32'(ctr));
        end
        check({tag, "_sweep_moves"}, 32'(sweep_moves), 32'(mv));
        check({tag, "_loads"},       32'(loads),       found ? 32'd2 : 32'd1);
        check({tag, "_seek_moves"},  32'(seek_moves),  found ? 32'(ctr) : 32'd0);
    endtask

    initial begin
        int ws, len, nlen, gap;
        bit hit;
        bus_if.start = 1'b0;
        rst = 1'b1;
        clear_map();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Single window 20..40, with START pokes while busy.
        clear_map();
        set_win(20, 40);
        run_training("win20_40", 1'b1);

        // Narrow window first, then a valid one.
        clear_map();
        set_win(10, 12);
        set_win(50, 60);
        run_training("narrow_then_50_60", 1'b0);

        // Nothing ever matches.
        clear_map();
        run_training("no_match", 1'b0);

        // Window running into the out-of-range end.
        clear_map();
        set_win(100, 127);
        oor_tap = 110;
        run_training("oor_110", 1'b0);

        // One corrupted word inside the CHECK phase of tap 30.
        clear_map();
        set_win(20, 40);
        corrupt_tap = 30;
        corrupt_k   = $urandom_range(22, 12);
        run_training("corrupt_30", 1'b0);

        // Randomised windows, optional narrow decoy and out-of-range end.
        for (int r = 0; r < 4; r++) begin
            clear_map();
            ws  = $urandom_range(90, 8);
            len = $urandom_range(25, 1);
            set_win(ws, (ws + len - 1 > 127) ? 127 : ws + len - 1);
            nlen = $urandom_range(3, 1);
            gap  = $urandom_range(4, 1);
            if (ws - gap - nlen >= 0) set_win(ws - gap - nlen, ws - gap - 1);
            if ($urandom_range(1, 0) == 1) oor_tap = $urandom_range(127, ws);
            run_training("random", 1'b0);
        end

        // Reset while seeking toward the centre of 20..40 (centre 30).
        clear_map();
        set_win(20, 40);
        loads = 0;
        @(negedge clk);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 20000 && !hit; c++) begin
            @(negedge clk);
            hit = (loads == 2) && (tap_m == 15) && bus_if.delay_line_move;
        end
        check("seek_tap15_reached", {31'd0, hit}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("seek_reset");

        // Training still works after the mid-run reset.
        clear_map();
        set_win(60, 70);
        run_training("after_reset", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
